// File: rtl/eeprom_pkg.sv
// Shared types, opcode constants and helpers for the serial EEPROM controller.
package eeprom_pkg;

    typedef enum logic [1:0] {
        Size128B = 2'd0,
        Size1KB  = 2'd1,
        Size2KB  = 2'd2,
        SizeNone = 2'd3
    } EEPROMSizeTypes;

    typedef enum logic [2:0] {
        CmdRead,
        CmdWrite,
        CmdErase,
        CmdWriteAll,
        CmdEraseAll
    } cmd_e;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StSpi,
        StDelay
    } state_e;

    // Ctrl register command nibbles (RegWData[7:4])
    localparam logic [3:0] NibRead  = 4'b0001;
    localparam logic [3:0] NibWrite = 4'b0010;
    localparam logic [3:0] NibErase = 4'b0100;
    localparam logic [3:0] NibAbort = 4'b1000;

    // Exact opcode matches for the broadcast / enable commands
    localparam logic [4:0] OpEwds     = 5'b10000;
    localparam logic [4:0] OpWriteAll = 5'b10001;
    localparam logic [4:0] OpEraseAll = 5'b10010;
    localparam logic [4:0] OpEwen     = 5'b10011;

    localparam logic [2:0] SelCtrl   = 3'd0;
    localparam logic [2:0] SelComLo  = 3'd1;
    localparam logic [2:0] SelComHi  = 3'd2;
    localparam logic [2:0] SelDataLo = 3'd3;
    localparam logic [2:0] SelDataHi = 3'd4;

    // Word-address width for a Size selection (before clamping to the memory depth)
    function automatic int unsigned addrbits(input logic [1:0] size);
        case (EEPROMSizeTypes'(size))
            Size128B: return 6;
            Size1KB:  return 9;
            default:  return 10;
        endcase
    endfunction

endpackage

// File: rtl/eeprom_spi_mirror.sv
// Shifts a 16- or 32-bit mirror frame out on the SPI port; frame index f starts at 0
// in the cycle after start_i.
module eeprom_spi_mirror (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        with_data_i,
    input  logic [15:0] cmd_i,
    input  logic [15:0] data_i,
    output logic        busy_o,
    output logic        spi_do_o,
    output logic        spi_sel_o,
    output logic        spi_clk_running_o
);
    logic [15:0] cmd_q, data_q;
    logic        with_q, busy_q, do_q, sel_q, run_q;
    logic [5:0]  cnt_q, cnt_nxt, last, cidx, didx;
    logic        bit_nxt;

    // Next frame index and the bit that belongs to it
    always_comb begin
        cnt_nxt = cnt_q + 6'd1;
        last    = with_q ? 6'd32 : 6'd16;
        cidx    = 6'd16 - cnt_nxt;
        didx    = 6'd32 - cnt_nxt;
        bit_nxt = (cnt_nxt <= 6'd16) ? cmd_q[cidx[3:0]] : data_q[didx[3:0]];
    end

    // Frame sequencer; busy covers f=0..L+1 so the caller sees the frame fully closed
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_q  <= 16'h0;
            data_q <= 16'h0;
            with_q <= 1'b0;
            cnt_q  <= 6'd0;
            busy_q <= 1'b0;
            do_q   <= 1'b0;
            sel_q  <= 1'b1;
            run_q  <= 1'b0;
        end else if (abort_i) begin
            cnt_q  <= 6'd0;
            busy_q <= 1'b0;
            do_q   <= 1'b0;
            sel_q  <= 1'b1;
            run_q  <= 1'b0;
        end else if (start_i) begin
            cmd_q  <= cmd_i;
            data_q <= data_i;
            with_q <= with_data_i;
            cnt_q  <= 6'd0;
            busy_q <= 1'b1;
            do_q   <= 1'b0;
            sel_q  <= 1'b0;
            run_q  <= 1'b1;
        end else if (busy_q) begin
            cnt_q <= cnt_nxt;
            do_q  <= (cnt_nxt <= last) ? bit_nxt : 1'b0;
            if (cnt_nxt == last)         run_q  <= 1'b0;
            if (cnt_nxt == last + 6'd1)  sel_q  <= 1'b1;
            if (cnt_q == last + 6'd1)    busy_q <= 1'b0;
        end
    end

    assign busy_o            = busy_q;
    assign spi_do_o          = do_q;
    assign spi_sel_o         = sel_q;
    assign spi_clk_running_o = run_q;

endmodule

// File: rtl/serial_eeprom_ctrl.sv
// 93Cxx-style serial EEPROM emulator: register decoder, command FSM, word memory,
// and an SPI mirror of every write/erase.
module serial_eeprom_ctrl
    import eeprom_pkg::*;
#(
    parameter int unsigned MAX_ADDR_BITS = 10,
    parameter int unsigned WRITE_DELAY   = 0
) (
    input  logic        sclk_i,
    input  logic        reset_i,
    input  logic [1:0]  size_i,
    input  logic        reg_wr_i,
    input  logic [2:0]  reg_sel_i,
    input  logic [7:0]  reg_wdata_i,
    output logic [7:0]  serial_ctrl_o,
    output logic [15:0] serial_com_o,
    output logic [15:0] serial_data_o,
    output logic        spi_do_o,
    output logic        spi_sel_o,
    output logic        spi_clk_running_o
);
    localparam int unsigned Words = 2 ** MAX_ADDR_BITS;
    typedef logic [MAX_ADDR_BITS-1:0] addr_t;

    state_e      state_q;
    cmd_e        cmd_q;
    logic [15:0] com_q, data_q, sdata_q, ram_rdata_q;
    logic        done_q, aborted_q, we_q, first_q, rd_pend_q, rd_ff_q;
    addr_t       fill_addr_q;
    logic [15:0] dly_q;
    logic [15:0] mem [Words];

    int unsigned eff_bits;
    addr_t       addr_mask, word_addr, mem_addr;
    logic [4:0]  op;
    logic [3:0]  nib;
    logic        is_idle, ctrl_wr, abort, fill_last, no_eeprom;
    logic        start_read, start_write, start_erase, start_wall, start_eall, ewen, ewds;
    logic        spi_start, spi_with_data, spi_busy, mem_we;
    logic [15:0] mem_wdata;

    // Command decode against the currently latched command register
    always_comb begin
        eff_bits  = (addrbits(size_i) > MAX_ADDR_BITS) ? MAX_ADDR_BITS : addrbits(size_i);
        addr_mask = addr_t'((32'd1 << eff_bits) - 32'd1);
        word_addr = addr_t'(com_q[9:0]) & addr_mask;
        op        = (size_i == 2'd0) ? com_q[8:4] : com_q[12:8];
        nib       = reg_wdata_i[7:4];
        no_eeprom = (EEPROMSizeTypes'(size_i) == SizeNone);
        is_idle   = (state_q == StIdle);
        ctrl_wr   = reg_wr_i && (reg_sel_i == SelCtrl);
        abort     = !is_idle && ctrl_wr && (nib == NibAbort);
        fill_last = (fill_addr_q == addr_mask);

        start_read  = is_idle && ctrl_wr && (nib == NibRead)  && (op[4:3] == 2'b10);
        start_write = is_idle && ctrl_wr && (nib == NibWrite) && (op[4:2] == 3'b101) && we_q;
        start_wall  = is_idle && ctrl_wr && (nib == NibWrite) && (op == OpWriteAll) && we_q;
        start_erase = is_idle && ctrl_wr && (nib == NibErase) && (op[4:2] == 3'b111) && we_q;
        start_eall  = is_idle && ctrl_wr && (nib == NibErase) && (op == OpEraseAll) && we_q;
        ewds        = is_idle && ctrl_wr && (nib == NibErase) && (op == OpEwds);
        ewen        = is_idle && ctrl_wr && (nib == NibErase) && (op == OpEwen);

        // The *ALL commands launch their frame on the last FILL edge
        spi_start     = start_write || start_erase ||
                        ((state_q == StFill) && fill_last && !abort);
        spi_with_data = start_write || ((state_q == StFill) && (cmd_q == CmdWriteAll));

        mem_we    = !no_eeprom && (((state_q == StSpi) && first_q) ||
                                   ((state_q == StFill) && !abort));
        mem_addr  = (state_q == StFill) ? fill_addr_q : word_addr;
        mem_wdata = (cmd_q == CmdErase || cmd_q == CmdEraseAll) ? 16'hFFFF : data_q;
    end

    // Word memory: synchronous write, synchronous read of the addressed word
    always_ff @(posedge sclk_i) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        ram_rdata_q <= mem[word_addr];
    end

    // Register file and command FSM
    always_ff @(posedge sclk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cmd_q       <= CmdRead;
            com_q       <= 16'h0;
            data_q      <= 16'h0;
            sdata_q     <= 16'h0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            we_q        <= 1'b0;
            first_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_ff_q     <= 1'b0;
            fill_addr_q <= '0;
            dly_q       <= 16'h0;
        end else begin
            rd_pend_q <= start_read;
            if (rd_pend_q) begin
                sdata_q <= rd_ff_q ? 16'hFFFF : ram_rdata_q;
                done_q  <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (reg_wr_i) begin
                        case (reg_sel_i)
                            SelComLo:  com_q[7:0]   <= reg_wdata_i;
                            SelComHi:  com_q[15:8]  <= reg_wdata_i;
                            SelDataLo: data_q[7:0]  <= reg_wdata_i;
                            SelDataHi: data_q[15:8] <= reg_wdata_i;
                            default: ;
                        endcase
                    end
                    if (start_read) rd_ff_q <= no_eeprom || !op[4];
                    if (ewds) we_q <= 1'b0;
                    if (ewen) we_q <= 1'b1;
                    if (start_write || start_erase || start_wall || start_eall) begin
                        done_q    <= 1'b0;
                        aborted_q <= 1'b0;
                    end
                    if (start_write || start_erase) begin
                        state_q <= StSpi;
                        first_q <= 1'b1;
                        cmd_q   <= start_write ? CmdWrite : CmdErase;
                    end
                    if (start_wall || start_eall) begin
                        state_q     <= StFill;
                        fill_addr_q <= '0;
                        cmd_q       <= start_wall ? CmdWriteAll : CmdEraseAll;
                    end
                end
                StFill: begin
                    if (abort) begin
                        state_q   <= StIdle;
                        aborted_q <= 1'b1;
                        done_q    <= 1'b1;
                    end else if (fill_last) begin
                        state_q <= StSpi;
                    end else begin
                        fill_addr_q <= fill_addr_q + addr_t'(1);
                    end
                end
                StSpi: begin
                    first_q <= 1'b0;
                    if (abort) begin
                        state_q   <= StIdle;
                        aborted_q <= 1'b1;
                        done_q    <= 1'b1;
                    end else if (!spi_busy) begin
                        if (WRITE_DELAY > 0) begin
                            state_q <= StDelay;
                            dly_q   <= 16'h0;
                        end else begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDelay: begin
                    dly_q <= dly_q + 16'd1;
                    if (abort) begin
                        state_q   <= StIdle;
                        aborted_q <= 1'b1;
                        done_q    <= 1'b1;
                    end else if (dly_q == 16'(WRITE_DELAY - 1)) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    eeprom_spi_mirror u_spi_mirror (
        .clk_i             (sclk_i),
        .rst_i             (reset_i),
        .start_i           (spi_start),
        .abort_i           (abort),
        .with_data_i       (spi_with_data),
        .cmd_i             (com_q),
        .data_i            (data_q),
        .busy_o            (spi_busy),
        .spi_do_o          (spi_do_o),
        .spi_sel_o         (spi_sel_o),
        .spi_clk_running_o (spi_clk_running_o)
    );

    assign serial_ctrl_o = {4'h0, aborted_q, we_q, is_idle, done_q};
    assign serial_com_o  = com_q;
    assign serial_data_o = sdata_q;

endmodule

// File: tb/tb_serial_eeprom_ctrl.sv
// Directed bench: two controller instances (no write delay, and an 8-cycle write delay).
module tb_serial_eeprom_ctrl;
    logic        clk = 1'b0;
    logic        rst1 = 1'b1, rst2 = 1'b1;
    logic [1:0]  size1 = 2'd1, size2 = 2'd1;
    logic        wr1 = 1'b0, wr2 = 1'b0;
    logic [2:0]  rsel1 = 3'd0, rsel2 = 3'd0;
    logic [7:0]  wd1 = 8'h0, wd2 = 8'h0;
    logic [7:0]  ctrl1, ctrl2;
    logic [15:0] com1, com2, sd1, sd2;
    logic        do1, do2, sel1, sel2, run1, run2;

    int cur = 0;
    int cyc = 0;
    int strobe_cyc = 0;
    int checks = 0;
    int errs = 0;

    logic [7:0]  m_ctrl;
    logic [15:0] m_com, m_sdata;
    logic        m_do, m_sel, m_run, m_ready;

    assign m_ctrl  = (cur == 0) ? ctrl1 : ctrl2;
    assign m_com   = (cur == 0) ? com1 : com2;
    assign m_sdata = (cur == 0) ? sd1 : sd2;
    assign m_do    = (cur == 0) ? do1 : do2;
    assign m_sel   = (cur == 0) ? sel1 : sel2;
    assign m_run   = (cur == 0) ? run1 : run2;
    assign m_ready = m_ctrl[1];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_eeprom_ctrl #(.MAX_ADDR_BITS(10), .WRITE_DELAY(0)) dut (
        .sclk_i(clk), .reset_i(rst1), .size_i(size1), .reg_wr_i(wr1), .reg_sel_i(rsel1),
        .reg_wdata_i(wd1), .serial_ctrl_o(ctrl1), .serial_com_o(com1), .serial_data_o(sd1),
        .spi_do_o(do1), .spi_sel_o(sel1), .spi_clk_running_o(run1)
    );

    serial_eeprom_ctrl #(.MAX_ADDR_BITS(10), .WRITE_DELAY(8)) dut_dly (
        .sclk_i(clk), .reset_i(rst2), .size_i(size2), .reg_wr_i(wr2), .reg_sel_i(rsel2),
        .reg_wdata_i(wd2), .serial_ctrl_o(ctrl2), .serial_com_o(com2), .serial_data_o(sd2),
        .spi_do_o(do2), .spi_sel_o(sel2), .spi_clk_running_o(run2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One-cycle register strobe; returns at the negedge after the strobe edge (cycle 1)
    task automatic wr(input logic [2:0] s, input logic [7:0] d);
        if (cur == 0) begin wr1 = 1'b1; rsel1 = s; wd1 = d; end
        else          begin wr2 = 1'b1; rsel2 = s; wd2 = d; end
        strobe_cyc = cyc;
        @(negedge clk);
        wr1 = 1'b0;
        wr2 = 1'b0;
    endtask

    task automatic set_com(input logic [15:0] v);
        wr(3'd1, v[7:0]);
        wr(3'd2, v[15:8]);
    endtask

    task automatic set_data(input logic [15:0] v);
        wr(3'd3, v[7:0]);
        wr(3'd4, v[15:8]);
    endtask

    task automatic wr_ctrl(input logic [3:0] n);
        wr(3'd0, {n, 4'h0});
    endtask

    task automatic wait_ready(output int c);
        int n = 0;
        while (!m_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) begin
            chk("ready_timeout", {31'h0, m_ready}, 32'h1);
            c = -1;
        end else begin
            c = cyc - strobe_cyc;
        end
    endtask

    task automatic wait_sel_low(output int c);
        int n = 0;
        while (m_sel && n < 3000) begin
            @(negedge clk);
            n++;
        end
        c = m_sel ? -1 : (cyc - strobe_cyc);
    endtask

    // Called in frame cycle f=0; collects bits f=1..nbits and counts SPISel-low cycles
    task automatic capture(input int nbits, output logic [31:0] fr, output int low);
        fr = 32'h0;
        low = 0;
        while (m_sel == 1'b0 && low < 100) begin
            if (low >= 1 && low <= nbits) fr = {fr[30:0], m_do};
            low++;
            @(negedge clk);
        end
    endtask

    task automatic count_sel_low(input int n, output int low);
        low = 0;
        for (int i = 0; i < n; i++) begin
            if (!m_sel) low++;
            @(negedge clk);
        end
    endtask

    task automatic do_read(input logic [15:0] com, output logic [15:0] v);
        set_com(com);
        wr_ctrl(4'h1);
        @(negedge clk);
        v = m_sdata;
    endtask

    initial begin
        logic [31:0] fr;
        logic [15:0] v;
        int          c, low;

        @(negedge clk);
        @(negedge clk);
        rst1 = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", {24'h0, m_ctrl}, 32'h02);
        chk("rst_com", {16'h0, m_com}, 32'h0);
        chk("rst_sdata", {16'h0, m_sdata}, 32'h0);
        chk("rst_sel", {31'h0, m_sel}, 32'h1);
        chk("rst_run", {31'h0, m_run}, 32'h0);
        chk("rst_do", {31'h0, m_do}, 32'h0);

        // WRITE while write-disabled is ignored
        set_com(16'h1412);
        set_data(16'hBEEF);
        wr_ctrl(4'h2);
        chk("nowe_ready", {31'h0, m_ready}, 32'h1);
        count_sel_low(40, low);
        chk("nowe_no_frame", low, 0);

        // EWEN, WRITE 0x012 <- 0xBEEF (Size=1)
        set_com(16'h1300);
        wr_ctrl(4'h4);
        chk("ewen_ctrl", {24'h0, m_ctrl}, 32'h06);
        set_com(16'h1412);
        wr_ctrl(4'h2);
        chk("wr_com_reg", {16'h0, m_com}, 32'h1412);
        chk("wr_ready_fall", {31'h0, m_ready}, 32'h0);
        capture(32, fr, low);
        chk("wr_frame", fr, 32'h1412BEEF);
        chk("wr_sel_low", low, 33);
        wait_ready(c);
        chk("wr_ready_ret", c, 36);

        // READ 0x012: two-cycle latency, Ready stays high
        set_com(16'h1012);
        wr_ctrl(4'h1);
        chk("rd_lat1", {16'h0, m_sdata}, 32'h0);
        chk("rd_ready", {31'h0, m_ready}, 32'h1);
        @(negedge clk);
        chk("rd_data", {16'h0, m_sdata}, 32'hBEEF);
        chk("rd_done", {31'h0, m_ctrl[0]}, 32'h1);

        // EWDS, then WRITE must leave memory alone
        set_com(16'h1000);
        wr_ctrl(4'h4);
        chk("ewds_we", {31'h0, m_ctrl[2]}, 32'h0);
        set_data(16'h1234);
        set_com(16'h1412);
        wr_ctrl(4'h2);
        chk("wd_ready", {31'h0, m_ready}, 32'h1);
        count_sel_low(40, low);
        chk("wd_no_frame", low, 0);
        do_read(16'h1012, v);
        chk("wd_mem_kept", {16'h0, v}, 32'hBEEF);

        // Size=0: EWEN, ERASEALL -> 64 FILL cycles then 16-bit frame
        size1 = 2'd0;
        set_com(16'h0130);
        wr_ctrl(4'h4);
        set_com(16'h0120);
        wr_ctrl(4'h4);
        wait_sel_low(c);
        chk("eall_fill_len", c, 65);
        capture(16, fr, low);
        chk("eall_frame", fr, 32'h0000_0120);
        chk("eall_sel_low", low, 17);
        wait_ready(c);
        chk("eall_ready_ret", c, 84);
        do_read(16'h0100, v);
        chk("eall_rd0", {16'h0, v}, 32'hFFFF);
        do_read(16'h013F, v);
        chk("eall_rd3f", {16'h0, v}, 32'hFFFF);

        // Size=2: word 100 <- 0x1111, then WRITEALL 0x55AA aborted at FILL cycle 100
        size1 = 2'd2;
        set_com(16'h1464);
        set_data(16'h1111);
        wr_ctrl(4'h2);
        wait_ready(c);
        set_data(16'h55AA);
        set_com(16'h1100);
        wr_ctrl(4'h2);
        count_sel_low(100, low);
        wr_ctrl(4'h8);
        chk("wall_abort_ctrl", {24'h0, m_ctrl}, 32'h0F);
        chk("wall_no_frame", low, 0);
        chk("wall_sel_after", {31'h0, m_sel}, 32'h1);
        do_read(16'h1000, v);
        chk("wall_rd0", {16'h0, v}, 32'h55AA);
        do_read(16'h1063, v);
        chk("wall_rd99", {16'h0, v}, 32'h55AA);
        do_read(16'h1064, v);
        chk("wall_rd100", {16'h0, v}, 32'h1111);

        // WRITE aborted at frame index 20
        set_com(16'h1405);
        set_data(16'hCAFE);
        wr_ctrl(4'h2);
        chk("ab_aborted_clr", {31'h0, m_ctrl[3]}, 32'h0);
        repeat (20) @(negedge clk);
        chk("ab_sel_f20", {31'h0, m_sel}, 32'h0);
        wr_ctrl(4'h8);
        chk("ab_sel", {31'h0, m_sel}, 32'h1);
        chk("ab_run", {31'h0, m_run}, 32'h0);
        chk("ab_ctrl", {24'h0, m_ctrl}, 32'h0F);
        do_read(16'h1005, v);
        chk("ab_mem", {16'h0, v}, 32'hCAFE);

        // WRITE_DELAY=8 instance
        cur = 1;
        size2 = 2'd1;
        set_com(16'h1300);
        wr_ctrl(4'h4);
        set_com(16'h1407);
        set_data(16'h7777);
        wr_ctrl(4'h2);
        wait_ready(c);
        chk("dly_ready_s1", c, 44);
        size2 = 2'd3;
        set_data(16'hA5A5);
        wr_ctrl(4'h2);
        capture(32, fr, low);
        chk("dly_frame", fr, 32'h1407A5A5);
        chk("dly_sel_low", low, 33);
        wait_ready(c);
        chk("dly_ready_s3", c, 44);
        do_read(16'h1007, v);
        chk("dly_rd_none", {16'h0, v}, 32'hFFFF);
        size2 = 2'd1;
        do_read(16'h1007, v);
        chk("dly_mem_kept", {16'h0, v}, 32'h7777);

        // Asynchronous reset mid-frame
        set_com(16'h1407);
        wr_ctrl(4'h2);
        repeat (10) @(negedge clk);
        chk("rr_sel_pre", {31'h0, m_sel}, 32'h0);
        rst2 = 1'b1;
        #1;
        chk("rr_sel", {31'h0, m_sel}, 32'h1);
        chk("rr_run", {31'h0, m_run}, 32'h0);
        chk("rr_ctrl", {24'h0, m_ctrl}, 32'h02);
        @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/serial_eeprom_ctrl.md
# serial_eeprom_ctrl

Parametrised, single-clock successor to the cartridge serial EEPROM emulator. It decodes the 93Cxx-style command set issued through the console's serial EEPROM registers and services reads and writes from an on-chip word memory. Every write or erase is mirrored as a frame on the SPI port. It adds configurable depth, a programmable write-cycle delay, command abort, and extra status bits, and sits between the bus register decoder and the SPI master mux.

## Interface
- MAX_ADDR_BITS, 10: memory depth is 2^MAX_ADDR_BITS 16-bit words; Size selections above it are clamped.
- WRITE_DELAY, 0: extra busy cycles after the SPI frame, emulating tWC; 0 means no recovery state.
- SClk  in  1  sole clock; everything is rising-edge.
- Reset  in  1  asynchronous, active-high.
- Size  in  2  0=128B (6 addr bits), 1=1KB (9), 2=2KB (10), 3=no EEPROM.
- RegWr  in  1  single-cycle register write strobe, synchronous to SClk.
- RegSel  in  3  0=ctrl, 1=com lo, 2=com hi, 3=data lo, 4=data hi; 5–7 are ignored.
- RegWData  in  8  register write data.
- SerialCtrl  out  8  {4'h0, Aborted, WriteEnabled, Ready, Done}.
- SerialCom  out  16  command register.
- SerialData  out  16  last read result.
- SPIDo  out  1  mirror serial data.
- SPISel  out  1  mirror chip select, active-low.
- SPIClkRunning  out  1  enables the gated SPI clock.

## Operation
- AddrMask = (1 << addrbits(Size)) - 1.
- Opcode op[4:0] = command[8:4] when Size=0, otherwise command[12:8]. Word address = command[9:0] & AddrMask.
- Ctrl writes in IDLE decode RegWData[7:4]:
  - 0001 with op=10???: READ.
  - 0010 with op=101??: WRITE. With op=10001: WRITEALL.
  - 0100 with op=111??: ERASE. With op=10010: ERASEALL. With op=10000: WriteEnabled<=0. With op=10011: WriteEnabled<=1.
  - Any other nibble or op is ignored.
- WRITE, ERASE, WRITEALL and ERASEALL start only if WriteEnabled=1. Starting one clears Done and Aborted.
- READ: SerialData <= memory word. It returns 16'hFFFF if op[4]=0 or Size=3. Done is set.
- States: IDLE → FILL (the *ALL commands only) → SPI → DELAY (only if WRITE_DELAY>0) → IDLE. Ready=1 only in IDLE.
- Memory writes:
  - WRITE and ERASE write one word in the first SPI cycle.
  - FILL writes address 0..AddrMask, one per cycle; data is the data register, or FFFF for ERASEALL.
  - Memory writes are suppressed when Size=3, but SPI frames are still sent.
- SPI frame, frame index f from 0:
  - f=0: SPISel<=0, SPIClkRunning<=1.
  - f=1..16: SPIDo=command[16-f].
  - f=17..32: SPIDo=data[32-f]; this range is sent only for WRITE and WRITEALL.
  - At the last bit L (16 or 32): SPIClkRunning<=0. At f=L+1: SPISel<=1, and the state advances.
  - SPIDo=0 outside the bit cycles.
- Abort (ctrl nibble 1000) while busy:
  - In FILL: stop immediately; words already written persist and no SPI frame is sent.
  - In SPI: SPIClkRunning<=0 and SPISel<=1 on the next edge.
  - In DELAY: end the delay.
  - Effect: return to IDLE, Aborted<=1, Done<=1. An abort issued in IDLE is ignored.
- While busy, writes to the command and data registers are ignored, and ctrl writes other than abort are ignored.
- Reset values: command=0, data=0, SerialData=0, Done=0, Aborted=0, WriteEnabled=0, SPISel=1, SPIClkRunning=0, SPIDo=0, state IDLE. Memory contents are not reset.

## Timing
- Register writes take effect on the SClk edge where RegWr=1 and are visible the next cycle.
- READ uses a synchronous RAM read: SerialData updates 2 cycles after the strobe. Ready stays 1 throughout.
- WRITE: Ready falls 1 cycle after the strobe. SPISel is low for 33 cycles. Ready returns 36+WRITE_DELAY cycles after the strobe.
- ERASE: same as WRITE with 16 bits, so SPISel is low for 17 cycles.
- *ALL commands add AddrMask+1 FILL cycles before the SPI state.
- A ctrl write coinciding with the cycle the state returns to IDLE is ignored; the software must see Ready=1 first.
- Asserting Reset mid-frame forces SPISel=1 and SPIClkRunning=0 asynchronously.

## Structure
- Package eeprom_pkg holds:
  - the EEPROMSizeTypes enum;
  - the Cmd enum (Read, Write, Erase, WriteAll, EraseAll);
  - the state enum;
  - opcode match constants;
  - RegSel codes;
  - the addrbits() function.
- Sub-module eeprom_spi_mirror: a frame shifter taking start, 16-bit command, 16-bit data, with_data and abort inputs, and returning busy. It owns SPIDo, SPISel and SPIClkRunning.

## Test plan
- Size=1: EWEN, then WRITE addr 0x012 with data 0xBEEF, then READ → SPI frame shows 0x1412 followed by 0xBEEF. SerialData=0xBEEF after 2 cycles, and Ready and Done are set.
- WriteEnabled=0 (after reset): WRITE → no SPI frame, Ready stays 1, memory unchanged.
- Size=0, EWEN, ERASEALL → 64 FILL cycles, then a 16-bit frame. Reading any address returns 0xFFFF.
- WRITEALL 0x55AA with Size=2; abort at FILL cycle 100 → words 0..99 read 0x55AA and word 100 keeps its old value. No SPISel low, Aborted=1.
- Abort at frame index f=20 of a WRITE → SPISel=1 on the next edge, memory word already written, Ready=1.
- WRITE_DELAY=8, Size=3: WRITE → full frame emitted, memory untouched, Ready returns 44 cycles after the strobe. Reset mid-frame forces SPISel=1 immediately.
